// File: rtl/collatz_stepper.sv
// -----------------------------------------------------------------------------
// collatz_stepper
//
// Purpose:
//   Loads a seed and advances the Collatz sequence by one step for every cycle
//   in which the tick input is high: n/2 when n is even, 3n+1 when n is odd.
//   Tracks the number of steps taken (saturating) and, optionally, the peak
//   value reached. Flags completion when the value reaches 1, and flags an
//   error when the seed is 0 or when 3n+1 no longer fits in W bits.
//   All outputs are registered and feed the display / LED driver stage.
//
// Build option:
//   COLLATZ_PEAK_EN - when defined, the peak register and its comparator are
//                     built. When undefined, peak is tied to zero and no peak
//                     logic exists.
//
// Parameters:
//   W - width of the seed / value / peak datapath in bits
//   S - width of the step counter in bits
//
// Ports:
//   clk   in   1  system clock (same domain as the tick generator)
//   arst  in   1  asynchronous active-high reset
//   start in   1  load request, honoured in IDLE, DONE and ERR
//   seed  in   W  starting value, captured when start is honoured
//   tick  in   1  step enable; one step per cycle it is high while running
//   value out  W  current sequence value
//   steps out  S  steps taken since load, saturating at all-ones
//   peak  out  W  largest value seen since load (zero without COLLATZ_PEAK_EN)
//   busy  out  1  high while the sequence is running
//   done  out  1  high once finished (reached 1) or errored, until next load
//   err   out  1  high after a zero seed or an overflow, until next load
// -----------------------------------------------------------------------------
module collatz_stepper #(
  parameter int W = 16,
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic [W-1:0] seed,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic [S-1:0] steps,
  output logic [W-1:0] peak,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [S-1:0]   STEPS_ONE = S'(1);
  localparam logic [W+1:0]   WIDE_ONE  = (W+2)'(1);
  localparam logic [W-1:0]   VAL_ZERO  = '0;
  localparam logic [W-1:0]   VAL_ONE   = W'(1);

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_value;
  logic [W-1:0]   w_value_next;
  logic [S-1:0]   r_steps;
  logic [S-1:0]   w_steps_next;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic [W+1:0]   w_triple;     // 3n+1 with two guard bits for overflow
  logic [W+1:0]   w_cand;       // candidate next value at W+2 bits
  logic           w_ovf;
  logic           w_is_one;
  logic           w_load;
  logic           w_step;
  logic [S-1:0]   w_steps_inc;

  // 3n+1 = n + 2n + 1. The maximum, 3*(2^W-1)+1, always fits in W+2 bits,
  // so any set bit above W-1 means the result cannot be represented.
  assign w_triple = {2'b00, r_value} + {1'b0, r_value, 1'b0} + WIDE_ONE;
  assign w_cand   = r_value[0] ? w_triple : {3'b000, r_value[W-1:1]};
  assign w_ovf    = r_value[0] & (|w_triple[W+1:W]);
  assign w_is_one = (w_cand == WIDE_ONE);

  // A load is honoured in every state except RUN; a tick that arrives with
  // a load is dropped because stepping only happens in RUN.
  assign w_load = start & (r_state != ST_RUN);
  assign w_step = tick  & (r_state == ST_RUN);

  // Counter sticks at all-ones instead of wrapping.
  assign w_steps_inc = (&r_steps) ? r_steps : r_steps + STEPS_ONE;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_value_next = r_value;
    w_steps_next = r_steps;

    if (w_load) begin
      w_value_next = seed;
      w_steps_next = '0;
      if (seed == VAL_ZERO) begin
        w_state_next = ST_ERR;
      end else if (seed == VAL_ONE) begin
        w_state_next = ST_DONE;
      end else begin
        w_state_next = ST_RUN;
      end
    end else if (w_step) begin
      if (w_ovf) begin
        // Value and step count freeze at the last representable step.
        w_state_next = ST_ERR;
      end else begin
        w_value_next = w_cand[W-1:0];
        w_steps_next = w_steps_inc;
        if (w_is_one) begin
          w_state_next = ST_DONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
      r_value <= '0;
      r_steps <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_value <= w_value_next;
      r_steps <= w_steps_next;
      // Status flags are decoded from the next state so they change on the
      // same edge as the state itself.
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE) || (w_state_next == ST_ERR);
      r_err   <= (w_state_next == ST_ERR);
    end
  end

  assign value = r_value;
  assign steps = r_steps;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

  // ---------------------------------------------------------------------------
  // Peak tracking
  // ---------------------------------------------------------------------------
`ifdef COLLATZ_PEAK_EN
  logic [W-1:0] r_peak;
  logic [W-1:0] w_peak_next;

  always_comb begin
    w_peak_next = r_peak;
    if (w_load) begin
      w_peak_next = seed;
    end else if (w_step && !w_ovf && (w_cand[W-1:0] > r_peak)) begin
      w_peak_next = w_cand[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_peak <= '0;
    end else begin
      r_peak <= w_peak_next;
    end
  end

  assign peak = r_peak;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_collatz_stepper.sv
// -----------------------------------------------------------------------------
// tb_collatz_stepper
//
// Three instances share clock, reset and stimulus:
//   dut_a  W=16 S=8   main configuration
//   dut_b  W=8  S=8   narrow datapath, sees seed[7:0], exercises overflow
//   dut_c  W=16 S=4   narrow step counter, exercises saturation
// Each instance has its own arithmetic reference model that is advanced on
// every clock edge and compared against all outputs one delta after the edge.
// Directed steps check the documented sequences with fixed constants; a
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_collatz_stepper;

`ifdef COLLATZ_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [15:0] seed;
  logic        tick;

  logic [15:0] value_a, peak_a;
  logic [7:0]  steps_a;
  logic        busy_a, done_a, err_a;
  logic [7:0]  value_b, peak_b;
  logic [7:0]  steps_b;
  logic        busy_b, done_b, err_b;
  logic [15:0] value_c, peak_c;
  logic [3:0]  steps_c;
  logic        busy_c, done_c, err_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  collatz_stepper #(.W(16), .S(8)) dut_a (
    .clk(clk), .arst(arst), .start(start), .seed(seed), .tick(tick),
    .value(value_a), .steps(steps_a), .peak(peak_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  collatz_stepper #(.W(8), .S(8)) dut_b (
    .clk(clk), .arst(arst), .start(start), .seed(seed[7:0]), .tick(tick),
    .value(value_b), .steps(steps_b), .peak(peak_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  collatz_stepper #(.W(16), .S(4)) dut_c (
    .clk(clk), .arst(arst), .start(start), .seed(seed), .tick(tick),
    .value(value_c), .steps(steps_c), .peak(peak_c),
    .busy(busy_c), .done(done_c), .err(err_c)
  );

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the sequence rules.
  // "running" is simply busy; loads are honoured whenever not running.
  // ---------------------------------------------------------------------------
  typedef struct {
    longint value;
    longint steps;
    longint peak;
    bit     busy;
    bit     done;
    bit     err;
  } mdl_t;

  mdl_t m_a, m_b, m_c;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.value = 0; r.steps = 0; r.peak = 0;
    r.busy = 1'b0; r.done = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit st, longint sd, bit tk, int w, int s);
    mdl_t   n;
    longint nx;
    longint vmax;
    longint smax;
    longint sdw;
    n    = m;
    vmax = (longint'(1) << w) - 1;
    smax = (longint'(1) << s) - 1;
    sdw  = sd & vmax;
    if (!m.busy) begin
      if (st) begin
        n.value = sdw;
        n.steps = 0;
        n.peak  = sdw;
        n.err   = (sdw == 0);
        n.done  = (sdw <= 1);
        n.busy  = (sdw > 1);
      end
    end else if (tk) begin
      nx = (m.value % 2 == 0) ? m.value / 2 : 3 * m.value + 1;
      if (nx > vmax) begin
        n.err  = 1'b1;
        n.done = 1'b1;
        n.busy = 1'b0;
      end else begin
        n.value = nx;
        n.steps = (m.steps < smax) ? m.steps + 1 : smax;
        if (nx > n.peak) n.peak = nx;
        if (nx == 1) begin
          n.done = 1'b1;
          n.busy = 1'b0;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_peak(mdl_t m);
    return PEAK_ON ? 32'(m.peak) : 32'd0;
  endfunction

  task automatic check_all();
    chk("a_value", 32'(value_a), 32'(m_a.value));
    chk("a_steps", 32'(steps_a), 32'(m_a.steps));
    chk("a_peak",  32'(peak_a),  exp_peak(m_a));
    chk("a_busy",  32'(busy_a),  32'(m_a.busy));
    chk("a_done",  32'(done_a),  32'(m_a.done));
    chk("a_err",   32'(err_a),   32'(m_a.err));
    chk("b_value", 32'(value_b), 32'(m_b.value));
    chk("b_steps", 32'(steps_b), 32'(m_b.steps));
    chk("b_peak",  32'(peak_b),  exp_peak(m_b));
    chk("b_flags", {29'd0, busy_b, done_b, err_b}, {29'd0, m_b.busy, m_b.done, m_b.err});
    chk("c_value", 32'(value_c), 32'(m_c.value));
    chk("c_steps", 32'(steps_c), 32'(m_c.steps));
    chk("c_peak",  32'(peak_c),  exp_peak(m_c));
    chk("c_flags", {29'd0, busy_c, done_c, err_c}, {29'd0, m_c.busy, m_c.done, m_c.err});
  endtask

  // Called at a falling edge; drives inputs, clocks once, advances the models,
  // checks, and returns at the next falling edge with start/tick cleared.
  task automatic step(input bit st, input int sd, input bit tk);
    start = st;
    seed  = 16'(sd);
    tick  = tk;
    @(posedge clk);
    m_a = mdl_next(m_a, st, longint'(sd), tk, 16, 8);
    m_b = mdl_next(m_b, st, longint'(sd), tk, 8, 8);
    m_c = mdl_next(m_c, st, longint'(sd), tk, 16, 4);
    #1;
    check_all();
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
  endtask

  logic [15:0] seq6 [8];
  int          cyc;
  int          rseed;

  initial begin
    seq6 = '{16'd3, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
    start = 1'b0; seed = '0; tick = 1'b0; arst = 1'b1;
    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    arst = 1'b0;
    $display("reset released");

    // Seed 6, eight ticks
    step(1'b1, 6, 1'b0);
    chk("s6_load_value", 32'(value_a), 32'd6);
    chk("s6_load_busy",  32'(busy_a),  32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 1'b1);
      chk($sformatf("s6_seq%0d", i), 32'(value_a), 32'(seq6[i]));
    end
    chk("s6_steps", 32'(steps_a), 32'd8);
    chk("s6_done",  32'(done_a),  32'd1);
    chk("s6_busy",  32'(busy_a),  32'd0);
    chk("s6_peak",  32'(peak_a),  PEAK_ON ? 32'd16 : 32'd0);
    $display("seed=6 value=%0d steps=%0d peak=%0d done=%0d", value_a, steps_a, peak_a, done_a);

    // Seed 27 to completion; dut_c saturates its 4-bit counter
    step(1'b1, 27, 1'b0);
    cyc = 0;
    while (busy_a && cyc < 400) begin
      step(1'b0, 0, 1'b1);
      cyc++;
    end
    chk("s27_done",    32'(done_a),  32'd1);
    chk("s27_value",   32'(value_a), 32'd1);
    chk("s27_steps",   32'(steps_a), 32'd111);
    chk("s27_peak",    32'(peak_a),  PEAK_ON ? 32'd9232 : 32'd0);
    chk("s27_c_steps", 32'(steps_c), 32'd15);
    chk("s27_c_value", 32'(value_c), 32'd1);
    $display("seed=27 value=%0d steps=%0d peak=%0d c_steps=%0d", value_a, steps_a, peak_a, steps_c);

    // Seed 1: straight to DONE, never busy
    step(1'b1, 1, 1'b0);
    chk("s1_done",  32'(done_a),  32'd1);
    chk("s1_steps", 32'(steps_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b1);
      chk("s1_busy", 32'(busy_a), 32'd0);
    end
    $display("seed=1 value=%0d done=%0d busy=%0d", value_a, done_a, busy_a);

    // Seed 0: error
    step(1'b1, 0, 1'b0);
    chk("s0_err",   32'(err_a),   32'd1);
    chk("s0_done",  32'(done_a),  32'd1);
    chk("s0_value", 32'(value_a), 32'd0);
    $display("seed=0 err=%0d done=%0d", err_a, done_a);

    // Seed 255 on the 8-bit instance: 766 overflows
    step(1'b1, 255, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("ovf_err",   32'(err_b),   32'd1);
    chk("ovf_done",  32'(done_b),  32'd1);
    chk("ovf_value", 32'(value_b), 32'd255);
    chk("ovf_steps", 32'(steps_b), 32'd0);
    step(1'b0, 0, 1'b1);
    chk("ovf_hold_value", 32'(value_b), 32'd255);
    chk("ovf_hold_steps", 32'(steps_b), 32'd0);
    chk("ovf_hold_err",   32'(err_b),   32'd1);
    $display("seed=255 W=8 err=%0d value=%0d", err_b, value_b);
    cyc = 0;
    while (busy_a && cyc < 400) begin
      step(1'b0, 0, 1'b1);
      cyc++;
    end
    chk("s255_a_done", 32'(done_a), 32'd1);

    // Tick held low for 100 cycles in RUN
    step(1'b1, 27, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    repeat (100) step(1'b0, 0, 1'b0);
    chk("idle_value", 32'(value_a), 32'd41);
    chk("idle_steps", 32'(steps_a), 32'd2);
    chk("idle_busy",  32'(busy_a),  32'd1);
    $display("tick low 100 cycles value=%0d steps=%0d", value_a, steps_a);

    // Asynchronous reset after five ticks
    repeat (3) step(1'b0, 0, 1'b1);
    chk("pre_rst_value", 32'(value_a), 32'd31);
    #2;
    arst = 1'b1;
    #1;
    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    check_all();
    chk("rst_value", 32'(value_a), 32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    step(1'b0, 0, 1'b1);
    chk("rst_idle_value", 32'(value_a), 32'd0);
    chk("rst_idle_busy",  32'(busy_a),  32'd0);
    $display("async reset mid-run value=%0d busy=%0d", value_a, busy_a);

    // Start with simultaneous tick while in DONE
    step(1'b1, 6, 1'b0);
    repeat (8) step(1'b0, 0, 1'b1);
    chk("st_tk_pre_done", 32'(done_a), 32'd1);
    step(1'b1, 7, 1'b1);
    chk("st_tk_value", 32'(value_a), 32'd7);
    chk("st_tk_steps", 32'(steps_a), 32'd0);
    chk("st_tk_busy",  32'(busy_a),  32'd1);
    $display("start+tick in DONE value=%0d steps=%0d", value_a, steps_a);

    // Randomized runs with random ticks and ignored mid-run starts
    for (int r = 0; r < 20; r++) begin
      cyc = 0;
      while (m_a.busy && cyc < 3000) begin
        step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 3000)),
             ($urandom_range(0, 1) == 1));
        cyc++;
      end
      chk("rand_drain", 32'(busy_a), 32'd0);
      rseed = int'($urandom_range(0, 3000));
      step(1'b1, rseed, ($urandom_range(0, 1) == 1));
      $display("random run %0d seed=%0d prev_steps_bound=%0d", r, rseed, cyc);
    end
    cyc = 0;
    while (m_a.busy && cyc < 3000) begin
      step(1'b0, 0, 1'b1);
      cyc++;
    end
    chk("rand_final_drain", 32'(busy_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/collatz_stepper.md
Name: collatz_stepper

Overview:
- Downstream consumer of the one-second tick generator.
- Loads a seed and advances the Collatz sequence by one step on each tick pulse: n/2 if n is even, 3n+1 if n is odd.
- Tracks the step count and the peak value, and flags completion (value reaches 1) or arithmetic overflow.
- Outputs feed the board display / LED driver stage.

Parameters:
- W, 16, width of seed/value/peak datapath in bits
- S, 8, width of step counter in bits

Ports:
- clk  input  1  system clock (same domain as tick generator)
- arst  input  1  reset, asynchronous, active-high
- start  input  1  load request; sampled on clk rising edge
- seed  input  W  starting value, captured when start accepted
- tick  input  1  one-cycle step-enable pulse from tick generator
- value  output  W  current sequence value
- steps  output  S  number of steps taken since load, saturating
- peak  output  W  maximum value seen since load (see Optional Feature)
- busy  output  1  high while in RUN
- done  output  1  high in DONE or ERR, held until next load
- err  output  1  high in ERR (seed 0 or 3n+1 overflow), held until next load

Behaviour:
- Reset (arst=1, async):
  - state=IDLE.
  - value=0, steps=0, peak=0, busy=0, done=0, err=0.
- FSM states: IDLE, RUN, DONE, ERR. All outputs are registered.
- Load, in IDLE, DONE or ERR with start=1 at a clk edge:
  - value<=seed, steps<=0, peak<=seed.
  - seed==0 -> ERR (err=1, done=1, busy=0).
  - seed==1 -> DONE (done=1, busy=0, steps=0).
  - else -> RUN (busy=1, done=0, err=0).
- start in RUN is ignored; there is no restart mid-run.
- start and tick high in the same cycle in IDLE/DONE/ERR: the load occurs and the tick is ignored.
- RUN, tick=0: all outputs hold.
- RUN, tick=1, value even:
  - next = value>>1.
- RUN, tick=1, value odd:
  - next = 3*value+1, computed at W+2 bits.
  - If next > 2^W-1: -> ERR. value, steps and peak hold; err=1, done=1, busy=0.
- Valid step:
  - value<=next[W-1:0].
  - steps<=steps+1, saturating at 2^S-1 (no wrap).
  - If next==1: -> DONE (done=1, busy=0) on the same edge.
- Latency: new value is visible the cycle after the edge where tick=1 is sampled. Exactly one step per tick pulse; a tick held high for k cycles gives k steps.
- DONE and ERR hold all outputs until the next start.
- Reset mid-run: immediate return to reset values; no residual state.
- tick is synchronous to clk; no synchronizer inside.

Optional Feature:
- Macro: COLLATZ_PEAK_EN
- Defined:
  - peak updates on each valid step, peak<=max(peak,next).
  - Load sets peak<=seed.
  - ERR holds peak.
- Undefined:
  - peak is tied to 0 permanently.
  - No comparator or register is synthesized.
  - All other behaviour is unchanged.

Test Plan:
- W=16, seed=6, start pulse, then 8 ticks:
  - value sequence 6,3,10,5,16,8,4,2,1.
  - steps=8, done=1, busy=0.
  - peak=16 with COLLATZ_PEAK_EN, 0 without.
- W=16, S=8, seed=27, run to completion:
  - steps=111, value=1, done=1.
  - peak=9232 (PEAK_EN).
  - With S=4 the same run gives steps=15 (saturated).
- seed=1 -> DONE next cycle, steps=0, busy never asserted.
- seed=0 -> err=1, done=1, value=0.
- W=8, seed=255, one tick:
  - 766 overflows -> err=1, done=1.
  - value=255, steps=0.
  - A further tick causes no change.
- Boundary and mid-run cases:
  - tick held low for 100 cycles in RUN -> no change.
  - arst pulsed mid-run (seed=27, after 5 ticks) -> all outputs 0, state IDLE.
  - start with simultaneous tick in DONE -> new seed loaded, steps=0.
